dec_unbinder_pack: RTL and testbench

Decoder-side counterpart of the encoder binder packs. It takes one pack of 10 bound (shifted) feature hypervectors and undoes each feature's binding permutation. It then identifies which level hypervector each unbound vector matches best by scanning the level item memory. It sits in the decode/readback path after the bound-vector store and produces a level index per feature for reconstruction and self-check of the encoder.

---
 rtl/dec_unbinder_pack_pkg.sv | 33 +++
 rtl/dec_unbinder_pack_hv_overlap.sv | 12 +
 rtl/dec_unbinder_pack.sv | 151 +++++++++++++++
 tb/tb_dec_unbinder_pack.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec_unbinder_pack_pkg.sv
// Shared constants for the decoder-side unbinder: vector width, per-feature
// binding shifts (shared with the encoder) and derived widths.
package dec_unbinder_pack_pkg;

  localparam int unsigned HV_DIM    = 128;
  localparam int unsigned FEATS     = 10;
  localparam int unsigned NUM_PACKS = 2;
  localparam int unsigned OV_W      = $clog2(HV_DIM + 1);
  localparam int unsigned FEAT_W    = $clog2(FEATS);
  localparam int unsigned SIDX_W    = $clog2(NUM_PACKS * FEATS);

  // Binder rotates left by these amounts; values are taken modulo HV_DIM.
  localparam int unsigned SHIFTS [NUM_PACKS*FEATS] = '{
    0, 127, 3, 17, 64, 128, 31, 100, 7, 90,
    5, 11, 23, 42, 77, 1, 126, 60, 99, 13
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNBIND = 2'd1,
    ST_SCAN   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Circular right rotation, undoing the binder's left rotation.
  function automatic logic [HV_DIM-1:0] rotr(input logic [HV_DIM-1:0] v,
                                             input int unsigned sh);
    int unsigned s;
    s = sh % HV_DIM;
    return HV_DIM'({v, v} >> s);
  endfunction

endpackage

// File: rtl/dec_unbinder_pack_hv_overlap.sv
// Combinational overlap: popcount of the bitwise AND of two hypervectors.
module hv_overlap
  import dec_unbinder_pack_pkg::*;
(
  input  logic [HV_DIM-1:0] a,
  input  logic [HV_DIM-1:0] b,
  output logic [OV_W-1:0]   overlap_c
);

  assign overlap_c = OV_W'($countones(a & b));

endmodule

// File: rtl/dec_unbinder_pack.sv
// Unbinds one pack of 10 bound feature hypervectors and finds the best
// matching level hypervector for each by a sequential item-memory scan.
module dec_unbinder_pack
  import dec_unbinder_pack_pkg::*;
#(
  parameter int unsigned PACK_ID     = 0,
  parameter int unsigned NUM_LEVELS  = 10,
  parameter int unsigned MIN_OVERLAP = 1
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          start_decoding,
  input  logic [HV_DIM-1:0]             bound_hv     [FEATS],
  input  logic [HV_DIM-1:0]             level_mem    [NUM_LEVELS],
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_LEVELS)-1:0] level_idx    [FEATS],
  output logic [OV_W-1:0]               best_overlap [FEATS],
  output logic                          match_valid  [FEATS]
);

  localparam int unsigned LVL_W = $clog2(NUM_LEVELS);

  state_e             state_q, state_d;
  logic [HV_DIM-1:0]  bound_q [FEATS];
  logic [HV_DIM-1:0]  bound_d [FEATS];
  logic [HV_DIM-1:0]  ub_q, ub_d;
  logic [FEAT_W-1:0]  feat_q, feat_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [OV_W-1:0]    best_q, best_d;
  logic [LVL_W-1:0]   best_idx_q, best_idx_d;
  logic [LVL_W-1:0]   lidx_q [FEATS];
  logic [LVL_W-1:0]   lidx_d [FEATS];
  logic [OV_W-1:0]    bov_q [FEATS];
  logic [OV_W-1:0]    bov_d [FEATS];
  logic               mv_q [FEATS];
  logic               mv_d [FEATS];
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [OV_W-1:0]    ov_c;
  logic               upd_c;
  logic [OV_W-1:0]    cand_best_c;
  logic [LVL_W-1:0]   cand_idx_c;
  logic [SIDX_W-1:0]  sidx_c;

  hv_overlap u_overlap (
    .a         (ub_q),
    .b         (level_mem[lvl_q]),
    .overlap_c (ov_c)
  );

  // Strict greater-than keeps the lowest level index on ties.
  assign upd_c       = ov_c > best_q;
  assign cand_best_c = upd_c ? ov_c  : best_q;
  assign cand_idx_c  = upd_c ? lvl_q : best_idx_q;
  assign sidx_c      = SIDX_W'(PACK_ID * FEATS) + SIDX_W'(feat_q);

  always_comb begin
    state_d    = state_q;
    bound_d    = bound_q;
    ub_d       = ub_q;
    feat_d     = feat_q;
    lvl_d      = lvl_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    lidx_d     = lidx_q;
    bov_d      = bov_q;
    mv_d       = mv_q;
    // Status outputs are registered images of the state, one cycle behind.
    busy_d     = (state_q == ST_UNBIND) || (state_q == ST_SCAN);
    done_d     = (state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (start_decoding) begin
          bound_d = bound_hv;
          lidx_d  = '{default: '0};
          bov_d   = '{default: '0};
          mv_d    = '{default: 1'b0};
          feat_d  = '0;
          state_d = ST_UNBIND;
        end
      end
      ST_UNBIND: begin
        ub_d       = rotr(bound_q[feat_q], SHIFTS[sidx_c]);
        best_d     = '0;
        best_idx_d = '0;
        lvl_d      = '0;
        state_d    = ST_SCAN;
      end
      ST_SCAN: begin
        best_d     = cand_best_c;
        best_idx_d = cand_idx_c;
        lvl_d      = lvl_q + LVL_W'(1);
        if (lvl_q == LVL_W'(NUM_LEVELS - 1)) begin
          lidx_d[feat_q] = cand_idx_c;
          bov_d[feat_q]  = cand_best_c;
          mv_d[feat_q]   = 32'(cand_best_c) >= MIN_OVERLAP;
          if (feat_q == FEAT_W'(FEATS - 1)) begin
            state_d = ST_DONE;
          end else begin
            feat_d  = feat_q + FEAT_W'(1);
            state_d = ST_UNBIND;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      bound_q    <= '{default: '0};
      ub_q       <= '0;
      feat_q     <= '0;
      lvl_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      lidx_q     <= '{default: '0};
      bov_q      <= '{default: '0};
      mv_q       <= '{default: 1'b0};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bound_q    <= bound_d;
      ub_q       <= ub_d;
      feat_q     <= feat_d;
      lvl_q      <= lvl_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      lidx_q     <= lidx_d;
      bov_q      <= bov_d;
      mv_q       <= mv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign level_idx    = lidx_q;
  assign best_overlap = bov_q;
  assign match_valid  = mv_q;

endmodule

// File: tb/tb_dec_unbinder_pack.sv
// Self-checking bench for dec_unbinder_pack: table of pack vectors run
// back-to-back through a scoreboard, plus ignored-start and mid-op reset.
module tb_dec_unbinder_pack;
  import dec_unbinder_pack_pkg::*;

  localparam int unsigned NF = FEATS;
  localparam int unsigned NL = 10;
  localparam int unsigned LW = $clog2(NL);

  typedef logic [HV_DIM-1:0] hv_t;

  typedef struct {
    hv_t bound   [NF];
    hv_t lvl     [NL];
    int  exp_idx [NF];
    int  exp_ov  [NF];
    int  exp_mv  [NF];
  } vec_t;

  logic            clk = 1'b0;
  logic            nrst;
  logic            start_decoding;
  logic [HV_DIM-1:0] bound_hv  [NF];
  logic [HV_DIM-1:0] level_mem [NL];
  logic            busy;
  logic            done;
  logic [LW-1:0]   level_idx    [NF];
  logic [OV_W-1:0] best_overlap [NF];
  logic            match_valid  [NF];

  vec_t vecs [4];
  vec_t sb_q [$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dec_unbinder_pack #(
    .PACK_ID     (0),
    .NUM_LEVELS  (NL),
    .MIN_OVERLAP (1)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start_decoding (start_decoding),
    .bound_hv       (bound_hv),
    .level_mem      (level_mem),
    .busy           (busy),
    .done           (done),
    .level_idx      (level_idx),
    .best_overlap   (best_overlap),
    .match_valid    (match_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic hv_t rotl(input hv_t v, input int unsigned s);
    hv_t r;
    int unsigned m;
    r = '0;
    m = s % HV_DIM;
    for (int j = 0; j < int'(HV_DIM); j++) r[(j + int'(m)) % int'(HV_DIM)] = v[j];
    return r;
  endfunction

  function automatic hv_t band(input int l);
    hv_t r;
    r = '0;
    for (int b = 0; b < 8; b++) r[l*8 + b] = 1'b1;
    return r;
  endfunction

  function automatic hv_t bits2(input int p0, input int p1);
    hv_t r;
    r = '0;
    r[p0] = 1'b1;
    r[p1] = 1'b1;
    return r;
  endfunction

  // Run one pack starting at the current negedge; returns at the negedge
  // where done is observed so the caller may start again immediately.
  task automatic run_vec(input int v, input int ign_at);
    int   n;
    bit   seen;
    vec_t e;
    bound_hv  = vecs[v].bound;
    level_mem = vecs[v].lvl;
    sb_q.push_back(vecs[v]);
    start_decoding = 1'b1;
    @(negedge clk);
    start_decoding = 1'b0;
    n = 0;
    seen = 0;
    chk($sformatf("v%0d_done_low_at_accept", v), 32'(done), 0);
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (n == ign_at) begin
        start_decoding = 1'b1;
        bound_hv = '{default: '0};
      end else begin
        start_decoding = 1'b0;
      end
      if (n == 1)   chk($sformatf("v%0d_busy_first", v), 32'(busy), 1);
      if (n == 10)  chk($sformatf("v%0d_ov0_cleared", v), 32'(best_overlap[0]), 0);
      if (n == 11)  chk($sformatf("v%0d_ov0_at_k11", v), 32'(best_overlap[0]), 32'(vecs[v].exp_ov[0]));
      if (n == 110) chk($sformatf("v%0d_busy_last", v), 32'(busy), 1);
      if (done) seen = 1;
    end
    start_decoding = 1'b0;
    chk($sformatf("v%0d_done_edge", v), seen ? 32'(n) : 32'hFFFF_FFFF, 111);
    chk($sformatf("v%0d_busy_at_done", v), 32'(busy), 0);
    e = sb_q.pop_front();
    for (int i = 0; i < int'(NF); i++) begin
      chk($sformatf("v%0d_level_idx%0d", v, i), 32'(level_idx[i]), 32'(e.exp_idx[i]));
      chk($sformatf("v%0d_best_ov%0d", v, i), 32'(best_overlap[i]), 32'(e.exp_ov[i]));
      chk($sformatf("v%0d_match_valid%0d", v, i), 32'(match_valid[i]), 32'(e.exp_mv[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;

    // Disjoint levels: each feature recovers its own level with 8 bits.
    for (int l = 0; l < int'(NL); l++) vecs[0].lvl[l] = band(l);
    for (int i = 0; i < int'(NF); i++) begin
      vecs[0].bound[i]   = rotl(band(i), SHIFTS[i]);
      vecs[0].exp_idx[i] = i;
      vecs[0].exp_ov[i]  = 8;
      vecs[0].exp_mv[i]  = 1;
    end
    // Tie: levels 3 and 5 identical; lowest index must win.
    for (int l = 0; l < int'(NL); l++) vecs[1].lvl[l] = band(l);
    vecs[1].lvl[5] = band(3);
    for (int i = 0; i < int'(NF); i++) begin
      vecs[1].bound[i]   = rotl(band(3), SHIFTS[i]);
      vecs[1].exp_idx[i] = 3;
      vecs[1].exp_ov[i]  = 8;
      vecs[1].exp_mv[i]  = 1;
    end
    // No match: all-zero bound vectors.
    for (int l = 0; l < int'(NL); l++) vecs[2].lvl[l] = band(l);
    for (int i = 0; i < int'(NF); i++) begin
      vecs[2].bound[i]   = '0;
      vecs[2].exp_idx[i] = 0;
      vecs[2].exp_ov[i]  = 0;
      vecs[2].exp_mv[i]  = 0;
    end
    // Wrap: patterns on both ends of the vector, shifts 0/127/128 in the pack.
    vecs[3].lvl[0] = bits2(0, int'(HV_DIM) - 1);
    vecs[3].lvl[1] = bits2(1, int'(HV_DIM) - 2);
    for (int l = 2; l < int'(NL); l++) vecs[3].lvl[l] = band(l);
    for (int i = 0; i < int'(NF); i++) begin
      vecs[3].bound[i]   = rotl(vecs[3].lvl[i % 2], SHIFTS[i]);
      vecs[3].exp_idx[i] = i % 2;
      vecs[3].exp_ov[i]  = 2;
      vecs[3].exp_mv[i]  = 1;
    end

    nrst = 1'b0;
    start_decoding = 1'b0;
    bound_hv  = '{default: '0};
    level_mem = '{default: '0};
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_level_idx0", 32'(level_idx[0]), 0);
    chk("reset_best_ov9", 32'(best_overlap[9]), 0);
    chk("reset_match_valid5", 32'(match_valid[5]), 0);
    nrst = 1'b1;
    @(negedge clk);

    // Table vectors back-to-back: each start lands in the IDLE cycle after done.
    for (int v = 0; v < 4; v++) run_vec(v, -1);

    // Second start while busy is ignored; results come from the first capture.
    run_vec(0, 50);
    @(negedge clk);
    chk("single_done_pulse", 32'(done), 0);

    // Reset in the middle of a run aborts it without done.
    bound_hv  = vecs[0].bound;
    level_mem = vecs[0].lvl;
    start_decoding = 1'b1;
    @(negedge clk);
    start_decoding = 1'b0;
    repeat (40) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_best_ov0", 32'(best_overlap[0]), 0);
    chk("midrst_level_idx2", 32'(level_idx[2]), 0);
    chk("midrst_match_valid1", 32'(match_valid[1]), 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    ndone = 0;
    repeat (150) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 0);

    // Fresh start after the aborted run completes normally.
    run_vec(0, -1);
    @(negedge clk);
    chk("final_done_low", 32'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
